ysyx_22050710_sram_arbiter: RTL
===============================

// Module: ysyx_22050710_sram_arbiter
// PURPOSE
//  Shares one SRAM-like memory port between the IF-stage inst master and the MEM-stage data master.
//  Both sides use the same req/addr_ok/data_ok protocol as the core's stage interfaces.
//  Arbitrates address phases, locks a grant while the slave stalls, and tracks in-flight owners
//  in an in-order ID FIFO so each data_ok/rdata returns to the master that issued the request.
//  Sits between the core's two SRAM-like ports and the memory/AXI bridge.
// PARAMETERS
//  SRAM_ADDR_WD   32  address width, all ports
//  SRAM_DATA_WD   64  data width, all ports
//  SRAM_WMASK_WD   8  write byte-strobe width
//  MAX_OUTST       4  max in-flight requests (ID FIFO depth), power of 2, >=2
// PORTS  (x = inst | data; both master ports are identical)
//  i_clk              in   1     clock
//  i_rst_n            in   1     asynchronous reset, active-low
//  i_x_sram_req       in   1     master request
//  i_x_sram_wr        in   1     1 = write (inst master ties to 0)
//  i_x_sram_size      in   2     0:1B 1:2B 2:4B 3:8B
//  i_x_sram_addr      in   AW    request address
//  i_x_sram_wstrb     in   MW    write byte enables
//  i_x_sram_wdata     in   DW    write data
//  o_x_sram_addr_ok   out  1     address accepted for this master
//  o_x_sram_data_ok   out  1     response for this master
//  o_x_sram_rdata     out  DW    read data (slave rdata, unmasked)
//  o_sram_req/wr/size/addr/wstrb/wdata  out  1/1/2/AW/MW/DW  muxed request to the slave
//  i_sram_addr_ok     in   1     slave accepted the address
//  i_sram_data_ok     in   1     slave response, in issue order
//  i_sram_rdata       in   DW    slave read data
// BEHAVIOUR
//  - Reset (i_rst_n low, async): FIFO empty, count=0, lock cleared.
//    All o_* outputs are 0 while reset is asserted.
//  - Grant, combinational, zero added latency:
//    - If lock is set, grant = lock_owner.
//    - Otherwise data wins over inst when both request.
//  - o_sram_req = granted master's req & ~fifo_full. Request fields mux from the granted master.
//    When idle, fields follow the inst master.
//  - o_x_sram_addr_ok = i_sram_addr_ok & o_sram_req & (grant==x).
//    The non-granted master never sees addr_ok.
//  - Lock FSM, 2 states:
//    - IDLE -> LOCKED(owner=grant) when o_sram_req & ~i_sram_addr_ok.
//    - LOCKED -> IDLE when o_sram_req & i_sram_addr_ok.
//    - A lower-priority request already presented to the slave is never swapped out before acceptance.
//  - ID FIFO, 1-bit entries, 0=inst 1=data:
//    - push on o_sram_req & i_sram_addr_ok.
//    - pop on i_sram_data_ok & ~empty.
//    - Pointers are log2(MAX_OUTST) bits and wrap modulo depth.
//    - count is log2(MAX_OUTST)+1 bits.
//    - Push and pop in the same cycle: count unchanged, both pointers advance. Legal even when full.
//  - full (count==MAX_OUTST): o_sram_req held 0 and no addr_ok issued.
//    A same-cycle pop does not unblock a push; the request issues next cycle.
//  - Response routing: o_x_sram_data_ok = i_sram_data_ok & ~empty & (head==x).
//    o_inst_sram_rdata and o_data_sram_rdata both carry i_sram_rdata.
//  - data_ok while empty is a protocol error: dropped, no output, no pointer change.
//    Simulation assertion fires.
//  - A request can be accepted in the same cycle its predecessor's data_ok arrives.
//    Back-to-back issue: one request per cycle.
// STRUCTURE
//  - Shared package ysyx_22050710_pkg holds:
//    - localparams ARB_ID_INST=1'b0 and ARB_ID_DATA=1'b1
//    - lock-FSM state encoding ARB_IDLE / ARB_LOCKED
//  - One sub-module, ysyx_22050710_id_fifo (WIDTH=1, DEPTH=MAX_OUTST).
//    It has a registered count, full/empty outputs, async active-low reset.
//  - The arbiter top holds the grant mux, lock FSM and response demux.
// TESTING
//  1. Single inst read at 0x8000_0000, slave addr_ok the same cycle, data_ok 2 cycles later
//     with rdata=0x1234 -> inst addr_ok=1 in cycle 0; inst data_ok=1 with rdata 0x1234 in cycle 2;
//     data port stays silent.
//  2. inst and data req in the same cycle, slave always ready -> data accepted first, inst next cycle.
//     The two data_ok pulses route data then inst.
//  3. inst req, slave addr_ok low for 3 cycles, data req rises in cycle 1
//     -> o_sram_addr stays the inst address until accepted; data is granted the cycle after.
//  4. MAX_OUTST=4, 5 data reads, no data_ok -> 4 accepted and the 5th is held (o_sram_req=0).
//     One data_ok -> the 5th is issued the following cycle.
//  5. Interleaved I,D,I,D issue, in-order responses 0xA..0xD -> inst gets 0xA,0xC and data gets 0xB,0xD.
//     The pointers wrap with no loss across 3 full laps.
//  6. Assert i_rst_n low with 3 requests in flight -> all outputs are 0 immediately and the FIFO empties.
//     After release a new inst read completes normally; a stray data_ok while empty is dropped.

Source files
------------

// File: rtl/ysyx_22050710_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050710_pkg
//  Description : Shared definitions for the SRAM-like port arbiter.
//                ARB_ID_*  : owner tags stored in the in-flight ID FIFO.
//                arb_state_e : lock FSM encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_22050710_pkg;

    localparam logic ARB_ID_INST = 1'b0;
    localparam logic ARB_ID_DATA = 1'b1;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/ysyx_22050710_id_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050710_id_fifo
//  Description : Small in-order FIFO recording which master owns each
//                outstanding request. Push and pop may happen together in
//                any state, including full (occupancy then stays the same).
//  Ports       : i_clk, i_rst_n (async, active-low)
//                i_push / i_din  : write one entry
//                i_pop           : retire the head entry
//                o_dout          : head entry
//                o_full, o_empty : occupancy flags from the registered count
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22050710_id_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                PTR_WD   = $clog2(DEPTH);
    localparam logic [PTR_WD:0]   FULL_CNT = (PTR_WD + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_WD-1:0] r_wr_ptr;
    logic [PTR_WD-1:0] r_rd_ptr;
    logic [PTR_WD:0]   r_count;

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; entries are only read when the count says valid.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/ysyx_22050710_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_22050710_sram_arbiter
//  Description : Shares one SRAM-like slave port between the inst (IF) and
//                data (MEM) masters. Data has priority; a grant is held while
//                the slave stalls an address phase; an ID FIFO routes each
//                in-order response back to the issuing master.
//  Ports       : i_clk, i_rst_n (async, active-low)
//                i_{inst,data}_sram_*  : master requests
//                o_{inst,data}_sram_*  : addr_ok / data_ok / rdata per master
//                o_sram_*              : muxed request to the slave
//                i_sram_addr_ok, i_sram_data_ok, i_sram_rdata : slave replies
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_22050710_sram_arbiter
    import ysyx_22050710_pkg::*;
#(
    parameter int SRAM_ADDR_WD  = 32,
    parameter int SRAM_DATA_WD  = 64,
    parameter int SRAM_WMASK_WD = 8,
    parameter int MAX_OUTST     = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    // inst master
    input  logic                     i_inst_sram_req,
    input  logic                     i_inst_sram_wr,
    input  logic [1:0]               i_inst_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_inst_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_inst_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_inst_sram_wdata,
    output logic                     o_inst_sram_addr_ok,
    output logic                     o_inst_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_inst_sram_rdata,
    // data master
    input  logic                     i_data_sram_req,
    input  logic                     i_data_sram_wr,
    input  logic [1:0]               i_data_sram_size,
    input  logic [SRAM_ADDR_WD-1:0]  i_data_sram_addr,
    input  logic [SRAM_WMASK_WD-1:0] i_data_sram_wstrb,
    input  logic [SRAM_DATA_WD-1:0]  i_data_sram_wdata,
    output logic                     o_data_sram_addr_ok,
    output logic                     o_data_sram_data_ok,
    output logic [SRAM_DATA_WD-1:0]  o_data_sram_rdata,
    // slave
    output logic                     o_sram_req,
    output logic                     o_sram_wr,
    output logic [1:0]               o_sram_size,
    output logic [SRAM_ADDR_WD-1:0]  o_sram_addr,
    output logic [SRAM_WMASK_WD-1:0] o_sram_wstrb,
    output logic [SRAM_DATA_WD-1:0]  o_sram_wdata,
    input  logic                     i_sram_addr_ok,
    input  logic                     i_sram_data_ok,
    input  logic [SRAM_DATA_WD-1:0]  i_sram_rdata
);

    arb_state_e r_state;
    logic       r_lock_owner;

    logic w_grant;
    logic w_gnt_data;
    logic w_req;
    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_sram_req;
    logic w_accept;
    logic w_pop;

    // A stalled address phase keeps its owner so the slave never sees the
    // presented request change before it is accepted.
    assign w_grant    = (r_state == ARB_LOCKED) ? r_lock_owner
                      : (i_data_sram_req ? ARB_ID_DATA : ARB_ID_INST);
    assign w_gnt_data = (w_grant == ARB_ID_DATA);
    assign w_req      = w_gnt_data ? i_data_sram_req : i_inst_sram_req;
    // Reset gating keeps every output low while i_rst_n is asserted.
    assign w_sram_req = w_req & ~w_full & i_rst_n;
    assign w_accept   = w_sram_req & i_sram_addr_ok;
    // Responses with nothing outstanding are discarded.
    assign w_pop      = i_sram_data_ok & ~w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ARB_IDLE;
            r_lock_owner <= ARB_ID_INST;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_sram_req && !i_sram_addr_ok) begin
                        r_state      <= ARB_LOCKED;
                        r_lock_owner <= w_grant;
                    end
                end
                ARB_LOCKED: begin
                    if (w_accept) r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    ysyx_22050710_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_accept),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Request fields follow the inst master whenever data is not granted.
    always_comb begin
        o_sram_req   = w_sram_req;
        o_sram_wr    = 1'b0;
        o_sram_size  = '0;
        o_sram_addr  = '0;
        o_sram_wstrb = '0;
        o_sram_wdata = '0;
        if (i_rst_n) begin
            if (w_gnt_data) begin
                o_sram_wr    = i_data_sram_wr;
                o_sram_size  = i_data_sram_size;
                o_sram_addr  = i_data_sram_addr;
                o_sram_wstrb = i_data_sram_wstrb;
                o_sram_wdata = i_data_sram_wdata;
            end else begin
                o_sram_wr    = i_inst_sram_wr;
                o_sram_size  = i_inst_sram_size;
                o_sram_addr  = i_inst_sram_addr;
                o_sram_wstrb = i_inst_sram_wstrb;
                o_sram_wdata = i_inst_sram_wdata;
            end
        end
    end

    assign o_inst_sram_addr_ok = w_accept & ~w_gnt_data;
    assign o_data_sram_addr_ok = w_accept &  w_gnt_data;
    assign o_inst_sram_data_ok = w_pop & (w_head == ARB_ID_INST);
    assign o_data_sram_data_ok = w_pop & (w_head == ARB_ID_DATA);
    assign o_inst_sram_rdata   = i_rst_n ? i_sram_rdata : '0;
    assign o_data_sram_rdata   = i_rst_n ? i_sram_rdata : '0;

    a_no_orphan_rsp: assert property (
        @(posedge i_clk) disable iff (!i_rst_n) !(i_sram_data_ok && w_empty)
    ) else $warning("sram data_ok with no outstanding request dropped");

endmodule
`default_nettype wire
